// File: rtl/count_capture_fifo_pkg.sv
// count_capture_fifo_pkg: shared defaults and the {wrap, data} entry layout used by the capture FIFO.
package count_capture_fifo_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    // At other widths the FIFO stores the same layout as a flat {wrap, data} vector.
    typedef struct packed {
        logic                 wrap;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;
endpackage

// File: rtl/count_capture_fifo_sync_fifo_core.sv
// sync_fifo_core: power-of-two deep FIFO storage with wrapping pointers and an explicit level count.
module sync_fifo_core #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    always_comb begin
        wr_d  = wr_q + AW'(push_i);
        rd_d  = rd_q + AW'(pop_i);
        lvl_d = lvl_q + LW'(push_i) - LW'(pop_i);
    end
    // Storage is reset too so the head reads as zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= din_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign level_o = lvl_q;
    assign full_o  = lvl_q == LW'(DEPTH);
    assign empty_o = lvl_q == '0;
endmodule

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: captures counter samples into a FIFO, tagging each with whether the counter wrapped
// since the previous accepted capture; dropped captures set a sticky overflow flag.
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       capture,
    input  logic                       clear_ovf,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_wrap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    logic [WIDTH-1:0] prev_q;
    logic             pend_q, pend_d, ovf_q, ovf_d;
    logic             push, pop, drop, wrap_now;
    always_comb begin
        wrap_now = (prev_q == '1) && (count_in == '0);
        pop      = out_valid && out_ready;
        push     = capture && (!full || pop);
        drop     = capture && full && !pop;
        pend_d   = push ? 1'b0 : (pend_q || wrap_now);
        ovf_d    = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= count_in;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end
    sync_fifo_core #(.W(WIDTH+1), .DEPTH(DEPTH)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({pend_q || wrap_now, count_in}),
        .dout_o  ({out_wrap, out_data}),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );
    assign out_valid = !empty;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_count_capture_fifo;
    localparam int W = 4;
    localparam int D = 4;
    logic         clk = 0, reset_n = 0;
    logic [W-1:0] count_in = 0;
    logic         capture = 0, clear_ovf = 0, out_ready = 0;
    logic [W-1:0] out_data;
    logic         out_wrap, out_valid, full, empty, overflow;
    logic [2:0]   level;
    int n_cmp = 0, n_fail = 0;
    int mq[$];
    int m_prev = 0;
    bit m_pend = 0, m_ovf = 0;

    count_capture_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .count_in(count_in), .capture(capture),
        .clear_ovf(clear_ovf), .out_data(out_data), .out_wrap(out_wrap),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_prev = 0;
        m_pend = 0;
        m_ovf  = 0;
    endtask

    // Drive one cycle's inputs, advance the model by the stated rules, then sample just after the edge.
    task automatic cyc(input bit cap, input int cnt, input bit rdy, input bit clr);
        bit pop, push, drop, wr;
        capture = cap; count_in = W'(cnt); out_ready = rdy; clear_ovf = clr;
        wr   = (m_prev == 15) && (cnt == 0);
        pop  = (mq.size() > 0) && rdy;
        push = cap && (mq.size() < D || pop);
        drop = cap && !push;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(((m_pend || wr) ? 16 : 0) + cnt);
        m_pend = push ? 0 : (m_pend || wr);
        m_ovf  = drop ? 1 : (clr ? 0 : m_ovf);
        m_prev = cnt;
        @(posedge clk);
        #1;
        capture = 0; out_ready = 0; clear_ovf = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        n_cmp += 7;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (empty !== 1'b1)     begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
        if (full !== 1'b0)      begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
        if (level !== 3'd0)     begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
        if (out_data !== 4'd0)  begin n_fail++; $display("FAIL rst_data got %0d want 0", out_data); end
        if (out_wrap !== 1'b0)  begin n_fail++; $display("FAIL rst_wrap got %b want 0", out_wrap); end
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_latency();
        cyc(1, 5, 0, 0);
        n_cmp += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
        if (out_data !== 4'd5)  begin n_fail++; $display("FAIL lat_data got %0d want 5", out_data); end
        if (out_wrap !== 1'b0)  begin n_fail++; $display("FAIL lat_wrap got %b want 0", out_wrap); end
        if (level !== 3'd1)     begin n_fail++; $display("FAIL lat_level got %0d want 1", level); end
        cyc(0, 6, 1, 0);
        n_cmp++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL lat_empty got %b want 1", empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 3; i <= 7; i++) cyc(1, i, 0, 0);
        n_cmp += 3;
        if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        if (level !== 3'd4)    begin n_fail++; $display("FAIL fill_level got %0d want 4", level); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", overflow); end
        for (int i = 3; i <= 6; i++) begin
            n_cmp++;
            if (out_data !== W'(i)) begin n_fail++; $display("FAIL drain_data got %0d want %0d", out_data, i); end
            cyc(0, 8, 1, 0);
        end
        n_cmp++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
        cyc(0, 8, 0, 1);
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        cyc(1, 9, 1, 0);
        n_cmp += 3;
        if (level !== 3'd4)    begin n_fail++; $display("FAIL fpp_level got %0d want 4", level); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b want 0", overflow); end
        if (out_data !== 4'd2) begin n_fail++; $display("FAIL fpp_head got %0d want 2", out_data); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_data !== W'((i < 3) ? i + 2 : 9)) begin
                n_fail++; $display("FAIL fpp_order got %0d want %0d", out_data, (i < 3) ? i + 2 : 9);
            end
            cyc(0, 10, 1, 0);
        end
    endtask

    task automatic test_wrap();
        cyc(0, 14, 0, 0);
        cyc(0, 15, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        n_cmp += 2;
        if (out_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_late got %b want 1", out_wrap); end
        if (out_data !== 4'd1) begin n_fail++; $display("FAIL wrap_late_data got %0d want 1", out_data); end
        cyc(1, 2, 1, 0);
        n_cmp += 2;
        if (out_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_next got %b want 0", out_wrap); end
        if (out_data !== 4'd2) begin n_fail++; $display("FAIL wrap_next_data got %0d want 2", out_data); end
        cyc(0, 15, 1, 0);
        cyc(1, 0, 0, 0);
        n_cmp += 2;
        if (out_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_edge got %b want 1", out_wrap); end
        if (out_data !== 4'd0) begin n_fail++; $display("FAIL wrap_edge_data got %0d want 0", out_data); end
        cyc(0, 1, 1, 0);
    endtask

    task automatic test_ovf_collision();
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        cyc(1, 5, 0, 1);
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL coll_ovf got %b want 1", overflow); end
        cyc(0, 6, 0, 1);
        n_cmp++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL coll_clr got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) cyc(0, 7, 1, 0);
    endtask

    task automatic test_reset_mid();
        cyc(1, 13, 0, 0);
        cyc(1, 14, 0, 0);
        cyc(1, 15, 0, 0);
        n_cmp++;
        if (level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", level); end
        #2;
        reset_n = 0;
        #1;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
        if (level !== 3'd0)     begin n_fail++; $display("FAIL mid_level got %0d want 0", level); end
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        cyc(1, 0, 0, 0);
        n_cmp += 2;
        if (out_wrap !== 1'b0) begin n_fail++; $display("FAIL mid_nowrap got %b want 0", out_wrap); end
        if (level !== 3'd1)    begin n_fail++; $display("FAIL mid_post_level got %0d want 1", level); end
        cyc(0, 1, 1, 0);
    endtask

    task automatic test_random();
        int cnt = 0;
        for (int k = 0; k < 400; k++) begin
            cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : (cnt + 1) % 16;
            cyc($urandom_range(0, 2) != 0, cnt, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            n_cmp += 4;
            if (level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level got %0d want %0d", level, mq.size()); end
            if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid got %b want %b", out_valid, mq.size() > 0); end
            if (full !== (mq.size() == D)) begin n_fail++; $display("FAIL rnd_full got %b want %b", full, mq.size() == D); end
            if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf got %b want %b", overflow, m_ovf); end
            if (mq.size() > 0) begin
                n_cmp++;
                if ({out_wrap, out_data} !== 5'(mq[0])) begin
                    n_fail++; $display("FAIL rnd_head got %0d want %0d", {out_wrap, out_data}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_ovf_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
